block_serial_subtractor: RTL



---
 rtl/block_serial_subtractor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor: multi-cycle unsigned A - B - borrow, one
// BLOCK_WIDTH slice per clock, LSB slice first, with borrow-bypass skip.
//
// Ports:
//   iClk, iRst        clock (rising edge), async active-high reset
//   iA, iB, iBorrow   minuend, subtrahend, borrow-in (sampled on accept)
//   iValid / oReady   input handshake (oReady high only in IDLE)
//   oDiff, oBorrow    result and borrow-out, stable while oValid
//   oValid / iReady   output handshake
//   oBypassCnt        blocks whose borrow took the bypass path
//                     (present only when BYPASS_STAT_EN is defined)
//
// Optional feature macro: BYPASS_STAT_EN
module block_serial_subtractor #(
  parameter int ADDER_WIDTH = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [ADDER_WIDTH-1:0] iA,
  input  logic [ADDER_WIDTH-1:0] iB,
  input  logic                   iBorrow,
  input  logic                   iValid,
  output logic                   oReady,
  output logic [ADDER_WIDTH-1:0] oDiff,
  output logic                   oBorrow,
  output logic                   oValid,
  input  logic                   iReady
`ifdef BYPASS_STAT_EN
  ,
  output logic [$clog2(ADDER_WIDTH/BLOCK_WIDTH+1)-1:0] oBypassCnt
`endif
);

  localparam int NB = ADDER_WIDTH / BLOCK_WIDTH;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW = BLOCK_WIDTH;
  localparam int AW = ADDER_WIDTH;
`ifdef BYPASS_STAT_EN
  localparam int CW = $clog2(NB + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [AW-1:0]   b_q, b_d;
  logic            brw_q, brw_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   diff_q, diff_d;
  logic            bout_q, bout_d;
`ifdef BYPASS_STAT_EN
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  // Current slice datapath
  logic [31:0]     base;
  logic [BW-1:0]   a_blk;
  logic [BW-1:0]   b_blk;
  logic [BW:0]     sum;
  logic            bypass;
  logic            brw_nxt;
  logic            last;

  always_comb begin
    base  = 32'(idx_q) * 32'(BW);
    a_blk = a_q[base +: BW];
    b_blk = b_q[base +: BW];
    // a - b - brw == a + ~b + ~brw (mod 2^BW); carry out means no borrow
    sum   = {1'b0, a_blk} + {1'b0, ~b_blk}
          + {{BW{1'b0}}, ~brw_q};
    // Equal slices propagate the incoming borrow unchanged; the ripple
    // result would agree, the bypass just shortens the path.
    bypass  = &(~(a_blk ^ b_blk));
    brw_nxt = bypass ? brw_q : ~sum[BW];
    last    = (idx_q == IW'(NB - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef BYPASS_STAT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          a_d     = iA;
          b_d     = iB;
          brw_d   = iBorrow;
          idx_d   = '0;
          state_d = S_RUN;
`ifdef BYPASS_STAT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RUN: begin
        diff_d[base +: BW] = sum[BW-1:0];
        brw_d = brw_nxt;
`ifdef BYPASS_STAT_EN
        cnt_d = cnt_q + CW'(bypass);
`endif
        if (last) begin
          bout_d  = brw_nxt;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (iReady) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef BYPASS_STAT_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oBypassCnt = cnt_q;
`endif

  assign oReady  = (state_q == S_IDLE);
  assign oValid  = (state_q == S_DONE);
  assign oDiff   = diff_q;
  assign oBorrow = bout_q;

endmodule
